// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Values arrive over valid/ready into a pending buffer
// and are committed to the display buffer only at a frame boundary
// (slot 3 -> slot 0), so a frame never shows a mix of old and new digits.
// DIG/SEG are registered from next-state values, so both pins change on
// the same edge and never glitch.
module seg7_scan_driver #(
  parameter int DIG_PERIOD = 50000, // cycles per digit slot, >= 2
  parameter int DEAD_CYC   = 500    // all-off cycles at slot start, 1..DIG_PERIOD-1
) (
  input  logic        FPGA_CLK,
  input  logic        RESET_BUT,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_blank,
  output logic [3:0]  DIG,
  output logic [7:0]  SEG
);

  localparam int CW = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIG_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(DEAD_CYC);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  localparam disp_t DISP_RST = '{data: 16'h0000, dp: 4'h0, blank: 4'hF};

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h3F;  4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;  4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;  4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;  4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;  4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;  4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;  4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;  default: hex2seg = 7'h71;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  disp_t         disp_q, disp_d, pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          rdy_q, rdy_d;
  logic [3:0]    dig_q, dig_d;
  logic [7:0]    seg_q, seg_d;

  logic          wrap, boundary, xfer, lit;
  logic [1:0]    idx;
  logic [3:0]    nib;

  // Scan counters, handshake/commit and next-cycle pin values.
  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (slot_q == 2'd3);
    xfer     = load_valid && rdy_q;

    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    slot_d = wrap ? slot_q + 2'd1 : slot_q;

    pend_d   = xfer ? '{data: load_data, dp: load_dp, blank: load_blank} : pend_q;
    disp_d   = (boundary && pend_v_q) ? pend_q : disp_q;

    // A transfer landing on the boundary edge sees pend_v_q = 0, so it only
    // fills pending and waits for the following boundary.
    pend_v_d = pend_v_q;
    if (xfer)          pend_v_d = 1'b1;
    else if (boundary) pend_v_d = 1'b0;

    // Ready drops right after a transfer and returns one edge after the
    // commit edge (pending already empty, ready still low).
    rdy_d = rdy_q;
    if (xfer)           rdy_d = 1'b0;
    else if (!pend_v_q) rdy_d = 1'b1;

    // Slot i shows the i-th nibble from the left; masks are MSB-leftmost.
    idx = 2'd3 - slot_d;
    case (slot_d)
      2'd0:    nib = disp_d.data[15:12];
      2'd1:    nib = disp_d.data[11:8];
      2'd2:    nib = disp_d.data[7:4];
      default: nib = disp_d.data[3:0];
    endcase
    lit = (cnt_d >= CNT_ON) && !disp_d.blank[idx];

    dig_d = 4'hF;
    seg_d = 8'hFF;
    if (lit) begin
      dig_d = ~(4'b0001 << slot_d);
      seg_d = ~{disp_d.dp[idx], hex2seg(nib)};
    end
  end

  // State and registered pin drivers.
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      cnt_q    <= '0;
      slot_q   <= 2'd0;
      disp_q   <= DISP_RST;
      pend_q   <= DISP_RST;
      pend_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      dig_q    <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      rdy_q    <= rdy_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
    end
  end

  assign load_ready = rdy_q;
  assign DIG        = dig_q;
  assign SEG        = seg_q;

endmodule
